// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Accepts one operation at a time, issues it for one cycle, then holds the
// registered response for the owning requester until it is consumed.
module alu_arbiter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_opt,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_opt,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [3:0]       alu_opt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_err,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]       r_state;
  logic             r_owner;   // requester holding the in-flight operation
  logic             r_last;    // requester granted most recently
  logic [3:0]       r_alu_opt;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [WIDTH-1:0] r_resp_result;
  logic             r_resp_zero;
  logic             r_resp_err;

  logic             w_idle;
  logic             w_grant0;
  logic             w_grant1;
  logic [3:0]       w_sel_opt;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic             w_legal;
  logic             w_owner_ready;

  assign w_idle = (r_state == IDLE);

  // On a tie the requester that was not granted last wins
  assign w_grant0 = w_idle && req0_valid && (!req1_valid || r_last);
  assign w_grant1 = w_idle && req1_valid && (!req0_valid || !r_last);

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  assign w_sel_opt = w_grant1 ? req1_opt : req0_opt;
  assign w_sel_a   = w_grant1 ? req1_a   : req0_a;
  assign w_sel_b   = w_grant1 ? req1_b   : req0_b;

  // Opcode legality for the operation being granted
  always_comb begin
    w_legal = 1'b0;
    case (w_sel_opt)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: w_legal = 1'b1;
      default:                                     w_legal = 1'b0;
    endcase
  end

  assign w_owner_ready = r_owner ? resp1_ready : resp0_ready;

  // Control FSM plus the ALU-side and response-side registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_owner       <= 1'b0;
      r_last        <= 1'b1;
      r_alu_opt     <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_resp_result <= '0;
      r_resp_zero   <= 1'b0;
      r_resp_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_owner <= w_grant1;
            r_last  <= w_grant1;
            if (w_legal) begin
              r_alu_opt <= w_sel_opt;
              r_alu_a   <= w_sel_a;
              r_alu_b   <= w_sel_b;
              r_state   <= ISSUE;
            end else begin
              // Illegal opcode bypasses the ALU; its ports keep prior values
              r_resp_result <= '0;
              r_resp_zero   <= 1'b0;
              r_resp_err    <= 1'b1;
              r_state       <= RESP;
            end
          end
        end
        ISSUE: begin
          r_resp_result <= alu_result;
          r_resp_zero   <= alu_zero;
          r_resp_err    <= 1'b0;
          r_state       <= RESP;
        end
        RESP: begin
          if (w_owner_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign alu_opt     = r_alu_opt;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign resp_result = r_resp_result;
  assign resp_zero   = r_resp_zero;
  assign resp_err    = r_resp_err;
  assign resp0_valid = (r_state == RESP) && !r_owner;
  assign resp1_valid = (r_state == RESP) && r_owner;
  assign busy        = !w_idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural shared ALU attached.
module tb_alu_arbiter;
  localparam int unsigned W = 64;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_opt, req1_opt;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   alu_opt;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         alu_zero;
  logic         resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [W-1:0] resp_result;
  logic         resp_zero, resp_err, busy;

  int checks = 0;
  int failures = 0;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opt(req0_opt),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opt(req1_opt),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_opt(alu_opt), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU
  always_comb begin
    alu_result = '0;
    case (alu_opt)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = alu_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_opt = 0; req1_opt = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    resp0_ready = 0; resp1_ready = 0;
    @(negedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    checks++; if (alu_opt !== 4'd0) begin failures++; $display("FAIL rst_alu_opt got=%0h exp=0", alu_opt); end
    checks++; if (alu_a !== '0 || alu_b !== '0) begin failures++; $display("FAIL rst_alu_ab got=%0h/%0h exp=0/0", alu_a, alu_b); end
    checks++; if (resp_result !== '0 || resp_zero !== 1'b0 || resp_err !== 1'b0) begin failures++; $display("FAIL rst_resp got=%0h/%0b/%0b exp=0/0/0", resp_result, resp_zero, resp_err); end
    checks++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%0b%0b exp=00", resp0_valid, resp1_valid); end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    @(negedge clk);
    req0_valid = 1; req0_opt = 4'b0010; req0_a = 5; req0_b = 7; resp0_ready = 1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL add_ready got=%0b%0b exp=10", req0_ready, req1_ready); end
    @(negedge clk);
    req0_valid = 0;
    checks++; if (alu_a !== 64'd5 || alu_b !== 64'd7 || alu_opt !== 4'b0010) begin failures++; $display("FAIL add_issue got=%0h/%0h/%0h exp=5/7/2", alu_a, alu_b, alu_opt); end
    checks++; if (resp0_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL add_c1 got=v%0b b%0b exp=v0 b1", resp0_valid, busy); end
    @(negedge clk);
    checks++; if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0) begin failures++; $display("FAIL add_rvalid got=%0b%0b exp=10", resp0_valid, resp1_valid); end
    checks++; if (resp_result !== 64'd12 || resp_zero !== 1'b0 || resp_err !== 1'b0) begin failures++; $display("FAIL add_result got=%0h/%0b/%0b exp=c/0/0", resp_result, resp_zero, resp_err); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || resp0_valid !== 1'b0) begin failures++; $display("FAIL add_done got=b%0b v%0b exp=b0 v0", busy, resp0_valid); end
    resp0_ready = 0;
  endtask

  task automatic test_tie();
    @(negedge clk);
    rst_n = 0;
    #1;
    @(negedge clk);
    rst_n = 1;
    req0_valid = 1; req0_opt = 4'b0110; req0_a = 9; req0_b = 9;
    req1_valid = 1; req1_opt = 4'b0001; req1_a = 3; req1_b = 4;
    resp0_ready = 1; resp1_ready = 1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL tie1_grant got=%0b%0b exp=10", req0_ready, req1_ready); end
    @(negedge clk);
    req0_valid = 0;
    checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL tie_issue_ready1 got=%0b exp=0", req1_ready); end
    @(negedge clk);
    checks++; if (resp0_valid !== 1'b1 || resp_result !== '0 || resp_zero !== 1'b1) begin failures++; $display("FAIL tie_sub got=v%0b r%0h z%0b exp=v1 r0 z1", resp0_valid, resp_result, resp_zero); end
    @(negedge clk);
    checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL tie_req1_grant got=%0b exp=1", req1_ready); end
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk);
    checks++; if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0 || resp_result !== 64'd7 || resp_zero !== 1'b0) begin failures++; $display("FAIL tie_or got=v%0b%0b r%0h z%0b exp=v01 r7 z0", resp0_valid, resp1_valid, resp_result, resp_zero); end
    @(negedge clk);
    req0_valid = 1; req1_valid = 1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL tie2_grant got=%0b%0b exp=10", req0_ready, req1_ready); end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    req0_valid = 1; req1_valid = 1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL withdraw_ptr got=%0b%0b exp=10", req0_ready, req1_ready); end
    req0_valid = 0; req1_valid = 0;
    resp0_ready = 0; resp1_ready = 0;
  endtask

  task automatic test_illegal();
    @(negedge clk);
    req1_valid = 1; req1_opt = 4'b0011; req1_a = 1; req1_b = 2; resp1_ready = 1;
    #1;
    checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL ill_grant got=%0b exp=1", req1_ready); end
    @(negedge clk);
    req1_valid = 0;
    checks++; if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0 || resp_err !== 1'b1 || resp_result !== '0 || resp_zero !== 1'b0) begin failures++; $display("FAIL ill_resp got=v%0b%0b e%0b r%0h z%0b exp=v01 e1 r0 z0", resp0_valid, resp1_valid, resp_err, resp_result, resp_zero); end
    checks++; if (alu_opt !== 4'b0001 || alu_a !== 64'd3 || alu_b !== 64'd4) begin failures++; $display("FAIL ill_alu_hold got=%0h/%0h/%0h exp=1/3/4", alu_opt, alu_a, alu_b); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ill_done got=%0b exp=0", busy); end
    resp1_ready = 0;
  endtask

  task automatic test_hold();
    @(negedge clk);
    req0_valid = 1; req0_opt = 4'b0010; req0_a = 10; req0_b = 20; resp0_ready = 0;
    @(negedge clk);
    req0_valid = 0; req1_valid = 1; req1_opt = 4'b0000; req1_a = 0; req1_b = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (resp0_valid !== 1'b1 || resp_result !== 64'd30 || busy !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL hold_c%0d got=v%0b r%0h b%0b rdy1=%0b exp=v1 r1e b1 rdy1=0", i, resp0_valid, resp_result, busy, req1_ready); end
      resp1_ready = (i == 1);
    end
    resp1_ready = 0;
    @(negedge clk);
    checks++; if (resp0_valid !== 1'b1 || resp_result !== 64'd30) begin failures++; $display("FAIL hold_after_pulse got=v%0b r%0h exp=v1 r1e", resp0_valid, resp_result); end
    resp0_ready = 1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || req1_ready !== 1'b1) begin failures++; $display("FAIL hold_release got=b%0b rdy1=%0b exp=b0 rdy1=1", busy, req1_ready); end
    req1_valid = 0; resp0_ready = 0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req0_valid = 1; req0_opt = 4'b0010; req0_a = 1; req0_b = 2; resp0_ready = 1;
    @(negedge clk);
    req0_valid = 0;
    checks++; if (alu_a !== 64'd1 || busy !== 1'b1) begin failures++; $display("FAIL mid_issue got=a%0h b%0b exp=a1 b1", alu_a, busy); end
    #2 rst_n = 0;
    #1;
    checks++; if (busy !== 1'b0 || alu_opt !== 4'd0 || alu_a !== '0 || alu_b !== '0 || resp_result !== '0 || resp0_valid !== 1'b0) begin failures++; $display("FAIL mid_async got=b%0b o%0h a%0h bb%0h r%0h v%0b exp=all0", busy, alu_opt, alu_a, alu_b, resp_result, resp0_valid); end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (resp0_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_noresp%0d got=v%0b b%0b exp=v0 b0", i, resp0_valid, busy); end
    end
    req0_valid = 1; req0_a = 4; req0_b = 4;
    #1;
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL mid_regrant got=%0b exp=1", req0_ready); end
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    checks++; if (resp0_valid !== 1'b1 || resp_result !== 64'd8) begin failures++; $display("FAIL mid_next got=v%0b r%0h exp=v1 r8", resp0_valid, resp_result); end
    @(negedge clk);
    resp0_ready = 0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_tie();
    test_illegal();
    test_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 64, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester n's operation this cycle.
REQ-006 req0_opt / req1_opt  input  4  ALU operation code (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PASS-B).
REQ-007 req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands.
REQ-008 alu_opt  output  4  registered operation code to the shared ALU.
REQ-009 alu_a, alu_b  output  WIDTH  registered operands to the shared ALU.
REQ-010 alu_result  input  WIDTH  combinational ALU result.
REQ-011 alu_zero  input  1  combinational ALU zero flag.
REQ-012 resp0_valid / resp1_valid  output  1  response for requester n held valid.
REQ-013 resp0_ready / resp1_ready  input  1  requester n consumes response.
REQ-014 resp_result  output  WIDTH  registered result, shared by both responses.
REQ-015 resp_zero  output  1  registered zero flag.
REQ-016 resp_err  output  1  registered illegal-opcode flag.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states IDLE, ISSUE, RESP; exactly one active.
REQ-019 IDLE: reqn_ready high only for the granted requester, combinationally from valids and priority pointer; both low in ISSUE and RESP.
REQ-020 Arbitration: one valid -> it is granted; both valid -> requester not granted last wins (round-robin); pointer updates only on an accepted handshake.
REQ-021 Handshake at edge (reqn_valid && reqn_ready): latch opt, a, b into alu_opt/alu_a/alu_b, latch owner id, go to ISSUE.
REQ-022 Illegal opcode (not in REQ-006 set) at handshake: skip ISSUE, go directly to RESP with resp_err=1, resp_result=0, resp_zero=0; ALU ports unchanged.
REQ-023 ISSUE lasts exactly one cycle; at its end edge capture alu_result into resp_result, alu_zero into resp_zero, resp_err=0, go to RESP.
REQ-024 RESP: respn_valid high only for owner; other resp valid low; outputs stable until consumed.
REQ-025 RESP with owner's resp_ready high at edge -> IDLE; the non-owner's resp_ready is ignored.
REQ-026 Latency: legal op handshake at edge N -> respn_valid high from cycle N+2; illegal op -> from N+1.
REQ-027 No new request accepted in the cycle a response is consumed; minimum 3 cycles per legal op, 2 per illegal.
REQ-028 ALU ports hold last issued values outside ISSUE.
REQ-029 Valid deasserted by a requester before handshake: no grant, pointer unchanged.

Reset
REQ-030 rst_n low asynchronously forces: state IDLE, alu_opt=0000, alu_a=0, alu_b=0, resp_result=0, resp_zero=0, resp_err=0, both resp valids 0, busy 0, pointer such that requester 0 wins the first tie.
REQ-031 Reset asserted in ISSUE or RESP discards the in-flight operation; no response produced after release.
REQ-032 After rst_n rises, first grant possible on the first rising edge with rst_n high.

Verification
REQ-033 Req0 only, opt=0010, a=5, b=7, resp0_ready=1 -> ready0 in cycle 0, alu_a=5/alu_b=7 in cycle 1, resp0_valid=1, resp_result=12, resp_zero=0 in cycle 2, busy low in cycle 3.
REQ-034 Both valid from reset, req0 SUB 9-9, req1 OR 3|4 -> req0 first (resp_result=0, resp_zero=1), then req1 (resp_result=7); next tie goes to req0.
REQ-035 Req1 opt=0011 -> resp1_valid one cycle after handshake, resp_err=1, resp_result=0; ALU ports unchanged.
REQ-036 Hold resp0_ready low 4 cycles in RESP, pulse resp1_ready -> resp0_valid and resp_result stable, no state change; req1_ready stays low.
REQ-037 Assert rst_n low during ISSUE -> all outputs to reset values immediately, no response after release; next req0 served normally.
